// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU slice.
//   op_e    : 4-bit operation codes understood by alu_seq (13 defined codes;
//             codes 13-15 are undefined and produce a zero result).
//   state_e : handshake/control states of alu_seq (IDLE, BUSY, DONE).
//   is_mul  : helper telling whether an op code takes the iterative path.
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_NOT  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_SLT  = 4'd6,
      OP_EQ   = 4'd7,
      OP_SLTU = 4'd8,
      OP_SLL  = 4'd9,
      OP_SRL  = 4'd10,
      OP_SRA  = 4'd11,
      OP_MUL  = 4'd12
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // MUL is the only op that goes through the multi-cycle datapath.
   function automatic logic is_mul(input logic [3:0] op);
      return op == OP_MUL;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add multiplier producing the low WIDTH bits of the
// unsigned product a*b, one partial-product step per clock.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   start           : load operands and begin (ignored while busy)
//   a, b            : multiplicand / multiplier
//   busy            : an operation is in progress
//   done            : high during the cycle whose clock edge performs the
//                     final step; product is valid in that same cycle
//   product         : running product including the current step
// Timing: start on edge E0, steps on edges E1..E(WIDTH), so busy is high
// for exactly WIDTH cycles and done coincides with the last of them.
// ---------------------------------------------------------------------------
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [CW-1:0]    count;

   // Next accumulator value: add the shifted multiplicand when the current
   // multiplier LSB is set. Exposed as the product so the consumer can grab
   // the finished value on the same edge as the final step.
   always_comb begin
      acc_next = acc;
      if (mplier[0]) begin
         acc_next = acc + mcand;
      end
   end

   assign done    = busy && (count == CW'(WIDTH - 1));
   assign product = acc_next;

   // Operand/accumulator registers. The multiplicand shifts left and the
   // multiplier shifts right so each step only ever inspects mplier[0];
   // bits shifted out of the multiplicand cannot affect the low WIDTH bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start && !busy) begin
         busy   <= 1'b1;
         count  <= '0;
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (done) begin
            busy  <= 1'b0;
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Sequential ALU with a valid/ready request port and a valid/ready result
// port. Single-cycle ops complete on the acceptance edge; MUL is handed to
// alu_mul_iter and takes WIDTH extra cycles.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid / in_ready        : request handshake (ready only in IDLE)
//   a, b, op                   : operands and 4-bit operation code
//   out_valid / out_ready      : result handshake (valid only in DONE)
//   result                     : registered WIDTH-bit result
//   carry, overflow, zero,
//   negative                   : registered flags matching result
// Shifts use only b[SHW-1:0] as the shift amount.
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   import alu_pkg::*;

   localparam int MSB = WIDTH - 1;

   state_e           state;
   state_e           next_state;
   logic             accept;
   logic             op_mul;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] diff;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign op_mul    = is_mul(op);
   assign mul_start = accept && op_mul;

   alu_mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle datapath. Carry/overflow are only meaningful for ADD/SUB
   // and stay 0 otherwise; MUL and undefined codes leave the result at 0
   // here (MUL's value comes from the multiplier instead).
   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      diff    = a - b;
      sh      = b[SHW-1:0];
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_c   = (a < b);
            alu_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         OP_NOT:  alu_res = ~a;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  alu_res = a << sh;
         OP_SRL:  alu_res = a >> sh;
         OP_SRA:  alu_res = $signed(a) >>> sh;
         default: alu_res = '0;
      endcase
   end

   // State register; reset wins over any request on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. The BUSY fallback to IDLE only matters if the
   // multiplier ever stops without signalling done, which keeps the FSM
   // from getting stuck.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               next_state = op_mul ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (mul_done) begin
               next_state = DONE;
            end else if (!mul_busy) begin
               next_state = IDLE;
            end
         end
         DONE: begin
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Result and flag registers. They only load on acceptance of a
   // single-cycle op or on the multiplier's last step, so they hold steady
   // for as long as the consumer stalls in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         result   <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
      end else if (accept && !op_mul) begin
         result   <= alu_res;
         carry    <= alu_c;
         overflow <= alu_v;
         zero     <= (alu_res == '0);
         negative <= alu_res[MSB];
      end else if ((state == BUSY) && mul_done) begin
         result   <= mul_product;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= (mul_product == '0);
         negative <= mul_product[MSB];
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq (WIDTH=8). Expected values come from an
// arithmetic reference model or from hand-derived constants.
// ---------------------------------------------------------------------------
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry;
   logic         overflow;
   logic         zero;
   logic         negative;

   int n_cmp = 0;
   int n_bad = 0;

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   // Reference model: plain integer arithmetic on the operand values.
   // Returns {result, carry, overflow, zero, negative}.
   function automatic logic [W+3:0] model(input int op_i, input int a_i, input int b_i);
      int mask = (1 << W) - 1;
      int half = 1 << (W - 1);
      int sa;
      int sb;
      int sh;
      int t;
      int res = 0;
      bit c = 1'b0;
      bit v = 1'b0;
      sa = (a_i >= half) ? a_i - (1 << W) : a_i;
      sb = (b_i >= half) ? b_i - (1 << W) : b_i;
      sh = b_i % W;
      case (op_i)
         0: begin
            res = (a_i + b_i) & mask;
            c   = (a_i + b_i) > mask;
            t   = sa + sb;
            v   = (t >= half) || (t < -half);
         end
         1: begin
            res = (a_i - b_i) & mask;
            c   = a_i < b_i;
            t   = sa - sb;
            v   = (t >= half) || (t < -half);
         end
         2:  res = ~a_i & mask;
         3:  res = a_i & b_i;
         4:  res = a_i | b_i;
         5:  res = a_i ^ b_i;
         6:  res = int'(sa < sb);
         7:  res = int'(a_i == b_i);
         8:  res = int'(a_i < b_i);
         9:  res = (a_i << sh) & mask;
         10: res = a_i >> sh;
         11: res = (sa >>> sh) & mask;
         12: res = (a_i * b_i) & mask;
         default: res = 0;
      endcase
      return {res[W-1:0], c, v, (res == 0), (res >= half)};
   endfunction

   // Presents one request at a negedge, lets it be accepted, then waits
   // (bounded) for out_valid. lat counts edges from the acceptance edge
   // (inclusive) to the edge after which out_valid is seen.
   task automatic applyStimulus(input int op_i, input int a_i, input int b_i, output int lat);
      @(negedge clk);
      op        = op_i[3:0];
      a         = a_i[W-1:0];
      b         = b_i[W-1:0];
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   // Accepts the pending result with a one-cycle out_ready pulse.
   task automatic releaseResult();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      op       = 4'd0;
      a        = 8'h05;
      b        = 8'h07;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid, result, carry, overflow, zero, negative} !== {2'b10, 12'h000}) begin
         n_bad++;
         $display("[TB] FAIL reset_state: got rdy=%b vld=%b res=%h flags=%b%b%b%b required rdy=1 vld=0 res=00 flags=0000",
                  in_ready, out_valid, result, carry, overflow, zero, negative);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_bad++;
         $display("[TB] FAIL reset_priority: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed();
      int          ops [7] = '{0, 1, 1, 6, 8, 11, 9};
      int          av  [7] = '{'hFF, 'h80, 'h01, 'h80, 'h80, 'h90, 'h81};
      int          bv  [7] = '{'h01, 'h01, 'h02, 'h01, 'h01, 'h02, 'h09};
      logic [W-1:0] er [7] = '{8'h00, 8'h7F, 8'hFF, 8'h01, 8'h00, 8'hE4, 8'h02};
      logic        ec  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        ev  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      int          lat;
      logic [W+3:0] exp_v;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(ops[i], av[i], bv[i], lat);
         exp_v = {er[i], ec[i], ev[i], (er[i] == '0), er[i][W-1]};
         n_cmp++;
         if ({result, carry, overflow, zero, negative} !== exp_v || lat != 1) begin
            n_bad++;
            $display("[TB] FAIL directed_%0d op=%0d: got res/flags=%h lat=%0d required %h lat=1",
                     i, ops[i], {result, carry, overflow, zero, negative}, lat, exp_v);
         end
         releaseResult();
         n_cmp++;
         if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("[TB] FAIL directed_release_%0d: got rdy=%b vld=%b required rdy=1 vld=0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_mul();
      @(negedge clk);
      op        = 4'd12;
      a         = 8'h0F;
      b         = 8'h11;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({in_ready, out_valid} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL mul_busy_cycle_%0d: got rdy=%b vld=%b required rdy=0 vld=0", k, in_ready, out_valid);
         end
         op       = 4'd0;
         a        = 8'h01;
         b        = 8'h01;
         in_valid = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, in_ready, result, carry, overflow, zero, negative} !== {2'b10, 8'hFF, 4'b0001}) begin
         n_bad++;
         $display("[TB] FAIL mul_done: got vld=%b rdy=%b res=%h flags=%b%b%b%b required vld=1 rdy=0 res=ff flags=0001",
                  out_valid, in_ready, result, carry, overflow, zero, negative);
      end
      releaseResult();
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_bad++;
         $display("[TB] FAIL mul_ignored_request: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_backpressure();
      int           lat;
      int           av;
      int           bv;
      logic [W+3:0] exp_v;
      av = $urandom_range(0, 255);
      bv = $urandom_range(0, 255);
      exp_v = model(1, av, bv);
      applyStimulus(1, av, bv, lat);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if ({result, carry, overflow, zero, negative} !== exp_v || {out_valid, in_ready} !== 2'b10) begin
            n_bad++;
            $display("[TB] FAIL hold_cycle_%0d: got res/flags=%h vld=%b rdy=%b required %h vld=1 rdy=0",
                     k, {result, carry, overflow, zero, negative}, out_valid, in_ready, exp_v);
         end
         @(posedge clk);
         @(negedge clk);
      end
      releaseResult();
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_bad++;
         $display("[TB] FAIL hold_release: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_abort();
      int           lat;
      logic [W+3:0] exp_v;
      @(negedge clk);
      op        = 4'd12;
      a         = W'($urandom_range(1, 255));
      b         = W'($urandom_range(1, 255));
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({out_valid, in_ready, result, carry, overflow, zero, negative} !== {2'b01, 12'h000}) begin
         n_bad++;
         $display("[TB] FAIL abort_state: got vld=%b rdy=%b res=%h flags=%b%b%b%b required vld=0 rdy=1 res=00 flags=0000",
                  out_valid, in_ready, result, carry, overflow, zero, negative);
      end
      for (int k = 0; k < W + 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL abort_no_result_%0d: got vld=%b required vld=0", k, out_valid);
         end
      end
      exp_v = model(0, 'h12, 'h34);
      applyStimulus(0, 'h12, 'h34, lat);
      n_cmp++;
      if ({result, carry, overflow, zero, negative} !== exp_v || lat != 1) begin
         n_bad++;
         $display("[TB] FAIL abort_then_add: got res/flags=%h lat=%0d required %h lat=1",
                  {result, carry, overflow, zero, negative}, lat, exp_v);
      end
      releaseResult();
   endtask

   task automatic test_random();
      int           lat;
      int           opv;
      int           av;
      int           bv;
      int           exp_lat;
      logic [W+3:0] exp_v;
      for (int i = 0; i < 40; i++) begin
         opv     = $urandom_range(0, 15);
         av      = $urandom_range(0, 255);
         bv      = $urandom_range(0, 255);
         exp_v   = model(opv, av, bv);
         exp_lat = (opv == 12) ? W + 1 : 1;
         applyStimulus(opv, av, bv, lat);
         n_cmp++;
         if ({result, carry, overflow, zero, negative} !== exp_v || lat != exp_lat) begin
            n_bad++;
            $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got res/flags=%h lat=%0d required %h lat=%0d",
                     i, opv, av[W-1:0], bv[W-1:0], {result, carry, overflow, zero, negative}, lat, exp_v, exp_lat);
         end
         releaseResult();
      end
   endtask

   // Main sequence: reset, then each scenario in turn, then the summary.
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 4'd0;
      a         = '0;
      b         = '0;
      test_reset();
      test_directed();
      test_mul();
      test_backpressure();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time limit so a stuck handshake can never hang the run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no completion after 1000000 ns required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
